// File: rtl/div_seq_if.sv
// EX <-> divider request/response bundle: operands and control from EX, {remainder, quotient} and ready back.
interface div_seq_if #(
  parameter int DATA_W = 32
);
  logic                  start_in;
  logic                  signed_div_in;
  logic [DATA_W-1:0]     dived_in;
  logic [DATA_W-1:0]     div_in;
  logic                  annul_in;
  logic [2*DATA_W-1:0]   res_out;
  logic                  rdy_out;

  modport master (
    output start_in, signed_div_in, dived_in, div_in, annul_in,
    input  res_out, rdy_out
  );

  modport slave (
    input  start_in, signed_div_in, dived_in, div_in, annul_in,
    output res_out, rdy_out
  );
endinterface

// File: rtl/div_seq.sv
// Radix-2 restoring divider sequencer for DIV/DIVU; res_out = {remainder, quotient}.
// Optional macro DIV_EARLY_TERM_EN: finish at acceptance when |dividend| < |divisor|.
module div_seq #(
  parameter int DATA_W = 32,
  parameter int CNT_W  = 6
) (
  input  logic     clk,
  input  logic     rst_n,
  div_seq_if.slave bus
);
  typedef enum logic [1:0] {IDLE, ZERO, ON, END} state_t;

  state_t              state;
  logic [CNT_W-1:0]    cnt;
  logic [DATA_W-1:0]   rem, quo, dsr;
  logic                neg_q, neg_r;
  logic [2*DATA_W-1:0] res;
  logic                rdy;

  logic                a_neg, b_neg;
  logic [DATA_W-1:0]   a_abs, b_abs;
  logic [DATA_W:0]     shrem, diff;
  logic                borrow;
  logic [DATA_W-1:0]   rem_nx, quo_nx, q_fix, r_fix;
  logic                stop;

  always_comb begin
    a_neg  = bus.signed_div_in & bus.dived_in[DATA_W-1];
    b_neg  = bus.signed_div_in & bus.div_in[DATA_W-1];
    // 0x80000000 negates to itself, which is the correct unsigned magnitude
    a_abs  = a_neg ? -bus.dived_in : bus.dived_in;
    b_abs  = b_neg ? -bus.div_in   : bus.div_in;
    // rem < dsr, so the shifted remainder fits DATA_W+1 bits and the diff msb is the borrow
    shrem  = {rem, quo[DATA_W-1]};
    diff   = shrem - {1'b0, dsr};
    borrow = diff[DATA_W];
    rem_nx = borrow ? shrem[DATA_W-1:0] : diff[DATA_W-1:0];
    quo_nx = {quo[DATA_W-2:0], ~borrow};
    q_fix  = neg_q ? -quo_nx : quo_nx;
    r_fix  = neg_r ? -rem_nx : rem_nx;
    stop   = bus.annul_in | ~bus.start_in;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= IDLE;
      cnt   <= '0;
      rem   <= '0;
      quo   <= '0;
      dsr   <= '0;
      neg_q <= 1'b0;
      neg_r <= 1'b0;
      res   <= '0;
      rdy   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.start_in && !bus.annul_in) begin
            if (bus.div_in == '0) begin
              state <= ZERO;
            end
`ifdef DIV_EARLY_TERM_EN
            else if (a_abs < b_abs) begin
              state <= END;
              res   <= {bus.dived_in, {DATA_W{1'b0}}};
              rdy   <= 1'b1;
            end
`endif
            else begin
              state <= ON;
              neg_q <= a_neg ^ b_neg;
              neg_r <= a_neg;
              quo   <= a_abs;
              dsr   <= b_abs;
              rem   <= '0;
              cnt   <= '0;
            end
          end
        end
        ZERO: begin
          if (stop) begin
            state <= IDLE;
          end else begin
            state <= END;
            res   <= '0;
            rdy   <= 1'b1;
          end
        end
        ON: begin
          if (stop) begin
            state <= IDLE;
            res   <= '0;
            rdy   <= 1'b0;
          end else begin
            rem <= rem_nx;
            quo <= quo_nx;
            cnt <= cnt + CNT_W'(1);
            if (cnt == CNT_W'(DATA_W-1)) begin
              state <= END;
              res   <= {r_fix, q_fix};
              rdy   <= 1'b1;
            end
          end
        end
        END: begin
          if (stop) begin
            state <= IDLE;
            res   <= '0;
            rdy   <= 1'b0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.res_out = res;
  assign bus.rdy_out = rdy;
endmodule

// File: tb/tb_div_seq.sv
// Scoreboard bench for div_seq: driver queues expected {rem,quo}/latency, monitor checks on rdy rise.
module tb_div_seq;
  localparam int DW = 32;
`ifdef DIV_EARLY_TERM_EN
  localparam int ET_LAT = 1;
`else
  localparam int ET_LAT = 33;
`endif

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  div_seq_if #(.DATA_W(DW)) bus();
  div_seq #(.DATA_W(DW), .CNT_W(6)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

  typedef struct {
    logic [63:0] res;
    int          lat;
    int          e0;
  } exp_t;

  exp_t sb[$];
  int   errors = 0;
  int   checks = 0;
  int   cyc    = 0;
  logic prev_rdy = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(string name, logic [63:0] act, logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, req);
    end
  endtask

  // monitor: every rising rdy must match the oldest queued expectation
  always @(negedge clk) begin
    exp_t e;
    if (bus.rdy_out && !prev_rdy) begin
      if (sb.size() == 0) begin
        check("unexpected_rdy", 64'd1, 64'd0);
      end else begin
        e = sb.pop_front();
        check("result", bus.res_out, e.res);
        check("latency", 64'(cyc - e.e0 + 1), 64'(e.lat));
      end
    end
    prev_rdy <= bus.rdy_out;
  end

  // drives a request at a negedge; the following posedge is E0
  task automatic start_op(bit sgn, logic [31:0] a, logic [31:0] b);
    @(negedge clk);
    bus.start_in      = 1'b1;
    bus.signed_div_in = sgn;
    bus.dived_in      = a;
    bus.div_in        = b;
  endtask

  task automatic scramble();
    bus.dived_in      = ~bus.dived_in;
    bus.div_in        = bus.div_in ^ 32'h5A5A_0001;
    bus.signed_div_in = ~bus.signed_div_in;
  endtask

  task automatic wait_rdy(string name);
    int n = 0;
    while (!bus.rdy_out && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (!bus.rdy_out) check({name, "_timeout"}, 64'd0, 64'd1);
  endtask

  task automatic watch_quiet(string name, int cycles);
    logic saw = 1'b0;
    repeat (cycles) begin
      @(negedge clk);
      saw = saw | bus.rdy_out;
    end
    check(name, 64'(saw), 64'd0);
  endtask

  task automatic run_op(string name, bit sgn, logic [31:0] a, logic [31:0] b,
                        logic [63:0] exp_res, int lat);
    exp_t e;
    start_op(sgn, a, b);
    e.res = exp_res; e.lat = lat; e.e0 = cyc + 1;
    sb.push_back(e);
    @(negedge clk);
    scramble();
    wait_rdy(name);
    @(negedge clk);
    check({name, "_hold_rdy"}, 64'(bus.rdy_out), 64'd1);
    check({name, "_hold_res"}, bus.res_out, exp_res);
    bus.start_in = 1'b0;
    @(negedge clk);
    check({name, "_drop_rdy"}, 64'(bus.rdy_out), 64'd0);
    check({name, "_drop_res"}, bus.res_out, 64'd0);
  endtask

  initial begin
    exp_t e;
    rst_n = 1'b0;
    bus.start_in = 1'b0; bus.signed_div_in = 1'b0; bus.annul_in = 1'b0;
    bus.dived_in = '0;   bus.div_in = '0;
    repeat (3) @(negedge clk);
    check("reset_rdy", 64'(bus.rdy_out), 64'd0);
    check("reset_res", bus.res_out, 64'd0);
    rst_n = 1'b1;

    run_op("divu_100_7",  1'b0, 32'd100,       32'd7,       {32'd2, 32'd14}, 33);
    run_op("div_m7_2",    1'b1, 32'hFFFFFFF9,  32'd2,       {32'hFFFFFFFF, 32'hFFFFFFFD}, 33);
    run_op("div_ovf",     1'b1, 32'h80000000,  32'hFFFFFFFF, {32'd0, 32'h80000000}, 33);
    run_op("divu_max_1",  1'b0, 32'hFFFFFFFF,  32'd1,       {32'd0, 32'hFFFFFFFF}, 33);
    run_op("div_7_m2",    1'b1, 32'd7,         32'hFFFFFFFE, {32'd1, 32'hFFFFFFFD}, 33);
    run_op("div_m100_m7", 1'b1, 32'hFFFFFF9C,  32'hFFFFFFF9, {32'hFFFFFFFE, 32'd14}, 33);
    run_op("divu_big",    1'b0, 32'hFFFFFFFF,  32'h00010000, {32'h0000FFFF, 32'h0000FFFF}, 33);
    run_op("div_by_zero", 1'b1, 32'd5,         32'd0,       64'd0, 2);
    run_op("divu_3_5",    1'b0, 32'd3,         32'd5,       {32'd3, 32'd0}, ET_LAT);
    run_op("div_m3_5",    1'b1, 32'hFFFFFFFD,  32'd5,       {32'hFFFFFFFD, 32'd0}, ET_LAT);

    // annul pulse at E0+10 with start dropped: no result ever
    start_op(1'b0, 32'd50, 32'd5);
    repeat (10) @(negedge clk);
    bus.annul_in = 1'b1; bus.start_in = 1'b0;
    @(negedge clk);
    bus.annul_in = 1'b0;
    watch_quiet("annul_no_rdy", 40);
    run_op("divu_9_3",    1'b0, 32'd9,         32'd3,       {32'd0, 32'd3}, 33);

    // start dropped mid-operation
    start_op(1'b0, 32'd9, 32'd3);
    repeat (5) @(negedge clk);
    bus.start_in = 1'b0;
    watch_quiet("drop_no_rdy", 40);

    // annul in END wins over a held start
    start_op(1'b0, 32'd100, 32'd7);
    e.res = {32'd2, 32'd14}; e.lat = 33; e.e0 = cyc + 1;
    sb.push_back(e);
    wait_rdy("annul_end");
    bus.annul_in = 1'b1;
    @(negedge clk);
    check("annul_end_rdy", 64'(bus.rdy_out), 64'd0);
    check("annul_end_res", bus.res_out, 64'd0);
    bus.annul_in = 1'b0; bus.start_in = 1'b0;

    // reset at E0+20 mid-operation
    start_op(1'b0, 32'd100, 32'd7);
    repeat (20) @(negedge clk);
    rst_n = 1'b0; bus.start_in = 1'b0;
    @(negedge clk);
    check("rst_mid_rdy", 64'(bus.rdy_out), 64'd0);
    rst_n = 1'b1;
    watch_quiet("rst_mid_no_rdy", 40);

    // reset while a result is presented
    start_op(1'b0, 32'hFFFFFFFF, 32'd1);
    e.res = {32'd0, 32'hFFFFFFFF}; e.lat = 33; e.e0 = cyc + 1;
    sb.push_back(e);
    wait_rdy("rst_end");
    rst_n = 1'b0; bus.start_in = 1'b0;
    @(negedge clk);
    check("rst_end_rdy", 64'(bus.rdy_out), 64'd0);
    check("rst_end_res", bus.res_out, 64'd0);
    rst_n = 1'b1;

    repeat (3) @(negedge clk);
    check("sb_drained", 64'(sb.size()), 64'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
